// File: rtl/nn_host_port_if.sv
// Host-port bundle: command stream, accelerator memory-mapped port, response
// stream and the perf counter. The master modport is the nn_host_port view;
// the slave modport is the view of the host transport plus accelerator.
interface nn_host_port_if #(
    parameter int unsigned MM_DEPTH = 16,
    parameter int unsigned MM_SIZE  = 32,
    parameter int unsigned Q_SIZE   = 16,
    parameter int unsigned LEN_W    = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_op;
    logic [MM_DEPTH-1:0] cmd_addr;
    logic [MM_SIZE-1:0]  cmd_data;
    logic [LEN_W-1:0]    cmd_len;
    logic                nn_write_enable;
    logic                nn_busy;
    logic [MM_DEPTH-1:0] nn_write_addr;
    logic [MM_SIZE-1:0]  nn_write_data;
    logic [MM_DEPTH-1:0] nn_read_addr;
    logic [Q_SIZE-1:0]   nn_read_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [Q_SIZE-1:0]   rsp_data;
    logic                rsp_last;
    logic [31:0]         perf_stall_cnt;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len,
        input  nn_busy, nn_read_data, rsp_ready,
        output cmd_ready, nn_write_enable, nn_write_addr, nn_write_data,
        output nn_read_addr, rsp_valid, rsp_data, rsp_last, perf_stall_cnt
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len,
        output nn_busy, nn_read_data, rsp_ready,
        input  cmd_ready, nn_write_enable, nn_write_addr, nn_write_data,
        input  nn_read_addr, rsp_valid, rsp_data, rsp_last, perf_stall_cnt
    );
endinterface

// File: rtl/nn_host_port.sv
// nn_host_port: host-side initiator for the accelerator memory-mapped port.
// Single-word WRITE commands are paced by nn_busy; READ bursts issue one
// address per cycle under a response-FIFO credit and return data as a
// valid/ready stream with rsp_last on the final word.
// Optional feature macro: NN_HOST_PERF_EN (busy-stall counter on perf_stall_cnt).
module nn_host_port #(
    parameter int unsigned MM_DEPTH  = 16,
    parameter int unsigned MM_SIZE   = 32,
    parameter int unsigned Q_SIZE    = 16,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    nn_host_port_if.master bus
);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [MM_DEPTH-1:0] r_wr_addr;
    logic [MM_SIZE-1:0]  r_wr_data;
    logic [MM_DEPTH-1:0] r_rd_addr;
    logic [LEN_W:0]      r_remaining;
    logic [RD_LAT-1:0]   r_if_v;
    logic [RD_LAT-1:0]   r_if_last;
    logic [Q_SIZE-1:0]   r_fifo_data [RSP_DEPTH];
    logic                r_fifo_last [RSP_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_accept;
    logic                w_issue;
    logic                w_credit;
    logic                w_last_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_rsp_valid;
    logic [31:0]         w_inflight;

    assign w_accept     = bus.cmd_valid & bus.cmd_ready;
    assign w_last_issue = (r_remaining == (LEN_W+1)'(1));
    assign w_push       = r_if_v[RD_LAT-1];
    assign w_rsp_valid  = (r_count != '0);
    assign w_pop        = w_rsp_valid & bus.rsp_ready;

    // Credit counts reads still in the latency pipe against free FIFO slots.
    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + 32'(r_if_v[i]);
        end
        w_credit = (32'(r_count) + w_inflight) < 32'(RSP_DEPTH);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; DRAIN exits on the cycle the last word is popped so
    // the FIFO-empty cycle is already IDLE and can accept a command.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = bus.cmd_op ? ST_READ : ST_WRITE;
            ST_WRITE: if (!bus.nn_busy) w_next = ST_IDLE;
            ST_READ:  if (w_issue && w_last_issue) w_next = ST_DRAIN;
            ST_DRAIN: if (w_inflight == '0 &&
                          (r_count == '0 || (r_count == CNT_W'(1) && w_pop)))
                          w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Output decode; write enable follows the current-cycle nn_busy.
    always_comb begin
        bus.cmd_ready       = 1'b0;
        bus.nn_write_enable = 1'b0;
        w_issue             = 1'b0;
        case (r_state)
            ST_IDLE:  bus.cmd_ready       = !reset;
            ST_WRITE: bus.nn_write_enable = !reset && !bus.nn_busy;
            ST_READ:  w_issue             = !reset && w_credit;
            default:  ;
        endcase
    end

    // Command latching, read address/remaining counters, in-flight tags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_if_v      <= '0;
            r_if_last   <= '0;
        end else begin
            if (w_accept) begin
                if (bus.cmd_op) begin
                    r_rd_addr   <= bus.cmd_addr;
                    r_remaining <= {1'b0, bus.cmd_len} + (LEN_W+1)'(1);
                end else begin
                    r_wr_addr <= bus.cmd_addr;
                    r_wr_data <= bus.cmd_data;
                end
            end else if (w_issue) begin
                r_rd_addr   <= r_rd_addr + MM_DEPTH'(1);
                r_remaining <= r_remaining - (LEN_W+1)'(1);
            end
            r_if_v[0]    <= w_issue;
            r_if_last[0] <= w_issue && w_last_issue;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_if_v[i]    <= r_if_v[i-1];
                r_if_last[i] <= r_if_last[i-1];
            end
        end
    end

    // Response FIFO storage; contents are discarded by clearing the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= bus.nn_read_data;
            r_fifo_last[r_wptr] <= r_if_last[RD_LAT-1];
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == PTR_W'(RSP_DEPTH-1)) ? '0 : r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= (r_rptr == PTR_W'(RSP_DEPTH-1)) ? '0 : r_rptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    assign bus.nn_write_addr = r_wr_addr;
    assign bus.nn_write_data = r_wr_data;
    assign bus.nn_read_addr  = r_rd_addr;
    assign bus.rsp_valid     = w_rsp_valid;
    assign bus.rsp_data      = r_fifo_data[r_rptr];
    assign bus.rsp_last      = w_rsp_valid & r_fifo_last[r_rptr];

`ifdef NN_HOST_PERF_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of WRITE cycles stalled by nn_busy.
    always_ff @(posedge clk) begin
        if (reset) r_stall_cnt <= '0;
        else if (r_state == ST_WRITE && bus.nn_busy && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign bus.perf_stall_cnt = r_stall_cnt;
`else
    assign bus.perf_stall_cnt = '0;
`endif
endmodule
